// File: rtl/run_length_fsm.sv
// Run-length detector: z rises once the last RUN_LEN enabled samples of w agree.
// State register is one-hot (ONEHOT=1) or binary (ONEHOT=0); both encodings are exported.
// Optional detect counter output det_cnt is enabled by defining RUN_LENGTH_FSM_DETCNT_EN.
module run_length_fsm #(
  parameter  int RUN_LEN = 2,
  parameter  int ONEHOT  = 1,
  localparam int NST     = 2*RUN_LEN + 1,
  localparam int SW      = $clog2(NST)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  input  logic           w,
  output logic           z,
  output logic           z_pulse,
  output logic           run_val,
  output logic [SW-1:0]  state_idx,
  output logic [NST-1:0] state_oh
`ifdef RUN_LENGTH_FSM_DETCNT_EN
  ,
  output logic [7:0]     det_cnt
`endif
);

  localparam logic [SW-1:0] IDX_IDLE = '0;
  localparam logic [SW-1:0] IDX_Z1   = SW'(1);
  localparam logic [SW-1:0] IDX_ZMAX = SW'(RUN_LEN);
  localparam logic [SW-1:0] IDX_O1   = SW'(RUN_LEN + 1);
  localparam logic [SW-1:0] IDX_OMAX = SW'(2*RUN_LEN);

  logic          legal;
  logic [SW-1:0] cur_idx;
  logic [SW-1:0] nxt_idx;
  logic [SW-1:0] target_idx;
  logic          step;
  logic          cur_det;
  logic          nxt_det;
  logic          z_pulse_q, z_pulse_d;

  // Successor of a legal state for the current w, in index space.
  always_comb begin
    // NOTE: default assignment first so every path drives nxt_idx and no latch is inferred.
    nxt_idx = cur_idx;
    if (cur_idx == IDX_IDLE) begin
      nxt_idx = w ? IDX_O1 : IDX_Z1;
    end else if (cur_idx <= IDX_ZMAX) begin
      nxt_idx = w ? IDX_O1 : ((cur_idx == IDX_ZMAX) ? IDX_ZMAX : cur_idx + SW'(1));
    end else begin
      nxt_idx = w ? ((cur_idx == IDX_OMAX) ? IDX_OMAX : cur_idx + SW'(1)) : IDX_Z1;
    end
  end

  // An illegal register value is recovered to IDLE on the next enabled or cleared cycle.
  assign step       = clr | en;
  assign target_idx = (clr || !legal) ? IDX_IDLE : nxt_idx;
  assign cur_det    = (cur_idx == IDX_ZMAX) || (cur_idx == IDX_OMAX);
  assign nxt_det    = (target_idx == IDX_ZMAX) || (target_idx == IDX_OMAX);
  assign z_pulse_d  = en & ~clr & nxt_det & ~cur_det;

  generate
    if (ONEHOT != 0) begin : g_onehot
      localparam logic [NST-1:0] OH_IDLE = {{(NST-1){1'b0}}, 1'b1};
      logic [NST-1:0] state_q, state_d;
      logic [SW-1:0]  acc;

      always_comb begin
        acc = '0;
        for (int i = 0; i < NST; i++) begin
          if (state_q[i]) acc = acc | SW'(i);
        end
        legal   = $onehot(state_q);
        cur_idx = legal ? acc : IDX_IDLE;
        state_d = step ? (OH_IDLE << target_idx) : state_q;
      end

      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= OH_IDLE;
        else        state_q <= state_d;
      end
    end else begin : g_binary
      localparam logic [SW-1:0] LAST_CODE = SW'(NST - 1);
      logic [SW-1:0] state_q, state_d;

      always_comb begin
        legal   = (state_q <= LAST_CODE);
        cur_idx = legal ? state_q : IDX_IDLE;
        state_d = step ? target_idx : state_q;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDX_IDLE;
        else        state_q <= state_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) z_pulse_q <= 1'b0;
    else        z_pulse_q <= z_pulse_d;
  end

  always_comb begin
    for (int i = 0; i < NST; i++) begin
      state_oh[i] = (cur_idx == SW'(i));
    end
  end

  assign state_idx = cur_idx;
  assign z         = cur_det;
  assign run_val   = (cur_idx >= IDX_O1);
  assign z_pulse   = z_pulse_q;

`ifdef RUN_LENGTH_FSM_DETCNT_EN
  logic [7:0] det_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             det_cnt_q <= 8'd0;
    else if (clr)                           det_cnt_q <= 8'd0;
    else if (z_pulse_d && det_cnt_q != 8'hFF) det_cnt_q <= det_cnt_q + 8'd1;
  end

  assign det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_run_length_fsm.sv
// Directed bench for run_length_fsm: three instances (RUN_LEN 2/4/3, mixed encodings)
// share one stimulus stream; each directed step checks the instance it targets.
module tb_run_length_fsm;

  logic clk = 1'b0;
  logic reset, en, clr, w;

  logic       z2, p2, rv2;
  logic [2:0] idx2;
  logic [4:0] oh2;
  logic       z4, p4, rv4;
  logic [3:0] idx4;
  logic [8:0] oh4;
  logic       z3, p3, rv3;
  logic [2:0] idx3;
  logic [6:0] oh3;
`ifdef RUN_LENGTH_FSM_DETCNT_EN
  logic [7:0] cnt2, cnt4, cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_length_fsm #(.RUN_LEN(2), .ONEHOT(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .w(w),
    .z(z2), .z_pulse(p2), .run_val(rv2), .state_idx(idx2), .state_oh(oh2)
`ifdef RUN_LENGTH_FSM_DETCNT_EN
    , .det_cnt(cnt2)
`endif
  );

  run_length_fsm #(.RUN_LEN(4), .ONEHOT(0)) dut4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .w(w),
    .z(z4), .z_pulse(p4), .run_val(rv4), .state_idx(idx4), .state_oh(oh4)
`ifdef RUN_LENGTH_FSM_DETCNT_EN
    , .det_cnt(cnt4)
`endif
  );

  run_length_fsm #(.RUN_LEN(3), .ONEHOT(1)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .w(w),
    .z(z3), .z_pulse(p3), .run_val(rv3), .state_idx(idx3), .state_oh(oh3)
`ifdef RUN_LENGTH_FSM_DETCNT_EN
    , .det_cnt(cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic c, input logic d);
    en = e; clr = c; w = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input int idx, input logic ez, input logic ep, input logic erv);
    check({tag, ".idx"}, 32'(idx2), 32'(idx));
    check({tag, ".oh"},  32'(oh2),  32'(1) << idx);
    check({tag, ".z"},   32'(z2),   32'(ez));
    check({tag, ".zp"},  32'(p2),   32'(ep));
    check({tag, ".rv"},  32'(rv2),  32'(erv));
  endtask

  task automatic chk4(input string tag, input int idx, input logic ez, input logic ep);
    check({tag, ".idx"}, 32'(idx4), 32'(idx));
    check({tag, ".oh"},  32'(oh4),  32'(1) << idx);
    check({tag, ".z"},   32'(z4),   32'(ez));
    check({tag, ".zp"},  32'(p4),   32'(ep));
  endtask

  task automatic chk3(input string tag, input int idx, input logic ez, input logic ep, input logic erv);
    check({tag, ".idx"}, 32'(idx3), 32'(idx));
    check({tag, ".oh"},  32'(oh3),  32'(1) << idx);
    check({tag, ".z"},   32'(z3),   32'(ez));
    check({tag, ".zp"},  32'(p3),   32'(ep));
    check({tag, ".rv"},  32'(rv3),  32'(erv));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk2("rst2", 0, 0, 0, 0);
    chk4("rst4", 0, 0, 0);
    chk3("rst3", 0, 0, 0, 0);
    reset = 1'b1;

    // RUN_LEN=2 one-hot: w = 0,0,0,1,1
    step(1, 0, 0); chk2("t1s1", 1, 0, 0, 0);
    step(1, 0, 0); chk2("t1s2", 2, 1, 1, 0);
    step(1, 0, 0); chk2("t1s3", 2, 1, 0, 0);
    step(1, 0, 1); chk2("t1s4", 3, 0, 0, 1);
    step(1, 0, 1); chk2("t1s5", 4, 1, 1, 1);

    // RUN_LEN=4 binary: w = 1,1,1,0,1,1,1,1
    step(1, 1, 0); chk4("t2clr", 0, 0, 0);
    step(1, 0, 1); chk4("t2s1", 5, 0, 0);
    step(1, 0, 1); chk4("t2s2", 6, 0, 0);
    step(1, 0, 1); chk4("t2s3", 7, 0, 0);
    step(1, 0, 0); chk4("t2s4", 1, 0, 0);
    step(1, 0, 1); chk4("t2s5", 5, 0, 0);
    step(1, 0, 1); chk4("t2s6", 6, 0, 0);
    step(1, 0, 1); chk4("t2s7", 7, 0, 0);
    step(1, 0, 1); chk4("t2s8", 8, 1, 1);
    check("t2.oh_top", 32'(oh4), 32'h100);
    check("t2.rv", 32'(rv4), 32'd1);
    step(1, 0, 1); chk4("t2abs", 8, 1, 0);

    // RUN_LEN=3: w=0 with en 1,0,1,0,1
    step(1, 1, 0); chk3("t3clr", 0, 0, 0, 0);
    step(1, 0, 0); chk3("t3s1", 1, 0, 0, 0);
    step(0, 0, 0); chk3("t3s2", 1, 0, 0, 0);
    step(1, 0, 0); chk3("t3s3", 2, 0, 0, 0);
    step(0, 0, 1); chk3("t3s4", 2, 0, 0, 0);
    step(1, 0, 0); chk3("t3s5", 3, 1, 1, 0);
    step(0, 0, 0); chk3("t3hold", 3, 1, 0, 0);

    // clr beats en in the detect state
    step(1, 1, 0); chk3("t4clr", 0, 0, 0, 0);

    // Asynchronous reset mid-run: dut3 in O2, dut2 just entered O2 (detect)
    step(1, 0, 1); chk3("t5o1", 4, 0, 0, 1);
    step(1, 0, 1); chk3("t5o2", 5, 0, 0, 1);
    chk2("t5d2", 4, 1, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk3("t5async3", 0, 0, 0, 0);
    chk2("t5async2", 0, 0, 0, 0);
    #1 reset = 1'b1;
    step(1, 0, 1); chk3("t5rel", 4, 0, 0, 1);

`ifdef RUN_LENGTH_FSM_DETCNT_EN
    step(1, 1, 0);
    check("t6clr0", 32'(cnt2), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 1);
      if (i == 4) check("t6mid", 32'(cnt2), 32'd10);
    end
    check("t6sat", 32'(cnt2), 32'd255);
    step(1, 1, 0);
    check("t6clr", 32'(cnt2), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_length_fsm.md
Name: run_length_fsm

Overview:
- Parametrised successor to the lab's fixed 5-state sequence detector. Asserts z once the last RUN_LEN sampled values of w are all equal (all 0s or all 1s).
- Internal state register is one-hot or binary, chosen by parameter. Both encodings are always exported on ports so LED banks can display either.
- Sits between the switch/button glue in top and the LED outputs. With RUN_LEN=2 it is behaviourally identical to the original A–E machine.

Parameters:
- RUN_LEN, 2, number of consecutive equal samples required for detection; legal range 2..15.
- ONEHOT, 1, internal state encoding: 1 = one-hot register of NST bits, 0 = binary register of SW bits.
- Derived, not overridable: NST = 2*RUN_LEN+1 states; SW = $clog2(NST).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- en, input, 1, sample strobe; w is consumed only on cycles with en=1.
- clr, input, 1, synchronous return to idle.
- w, input, 1, serial data bit.
- z, output, 1, Moore detect flag.
- z_pulse, output, 1, one-cycle strobe on entry into a detect state.
- run_val, output, 1, value of the current run (0 in idle).
- state_idx, output, SW, binary state index.
- state_oh, output, NST, one-hot state vector.

Behaviour:
- Reset: one clock, clk. reset is asynchronous and active-low; while reset=0 the FSM is forced to IDLE.
- Reset values: state_idx=0, state_oh=1 (bit 0 set), z=0, z_pulse=0, run_val=0. Deassertion takes effect on the next rising clk.
- States:
  - IDLE, index 0.
  - Zk (k consecutive 0s, k=1..RUN_LEN), index k.
  - Ok (k consecutive 1s), index RUN_LEN+k.
- Transitions, evaluated only when en=1 and clr=0:
  - w=0: IDLE→Z1; Zk→Z(k+1) for k<RUN_LEN; Z_RUN_LEN→Z_RUN_LEN (absorbing); any Ok→Z1.
  - w=1: symmetric on the O chain; any Zk→O1.
- en=0: state holds; z holds; z_pulse=0.
- clr=1: next state IDLE regardless of en or w (clr beats en). z_pulse=0 on that cycle.
- Output decode (all registered or decoded from state only; no combinational path from w):
  - z = 1 iff state is Z_RUN_LEN or O_RUN_LEN.
  - run_val = 1 iff state is an Ok.
  - z_pulse = registered; 1 for exactly one cycle after a transition from a non-detect state into Z_RUN_LEN or O_RUN_LEN. Staying in the absorbing state does not re-pulse. Flipping directly from a run of 0s to a run of 1s never skips states, so it cannot re-pulse without passing through O1..O(RUN_LEN-1).
- Latency: w sampled at edge n is reflected in state_idx, z and z_pulse after edge n, i.e. one cycle.
- Encoding equivalence: state_idx and state_oh are consistent every cycle; state_oh == (1 << state_idx) for both values of ONEHOT.
- ONEHOT=1 robustness: any illegal register value (zero-hot or multi-hot) goes to IDLE on the next enabled or cleared cycle. While illegal, decoded outputs read as IDLE.
- ONEHOT=0 robustness: binary codes ≥ NST are handled the same way.
- Reset mid-run: asynchronous return to IDLE. A run in progress is discarded and z drops immediately, without waiting for clk.

Optional Feature:
- Macro: RUN_LENGTH_FSM_DETCNT_EN.
- When defined: adds output det_cnt [7:0], a saturating count of z_pulse events.
  - Reset value 0; also cleared by clr.
  - Holds at 255; never wraps.
- When undefined: the port and counter are absent, and all other behaviour is unchanged.

Test Plan:
1. RUN_LEN=2, ONEHOT=1, en=1; w = 0,0,0,1,1 → state_idx 1,2,2,3,4; z 0,1,1,0,1; z_pulse high on the 2nd and 5th samples only.
2. RUN_LEN=4, ONEHOT=0; w = 1,1,1,0,1,1,1,1 → z low until the 8th sample, then 1; state_idx ends at 8; state_oh = 9'h100.
3. RUN_LEN=3; w=0 with en toggling 1,0,1,0,1 → state advances only on en=1 cycles (Z1,Z1,Z2,Z2,Z3); z=1 after the 5th cycle.
4. In Z3 with z=1, assert clr=1 and en=1 with w=0 in the same cycle → next state IDLE, z=0, z_pulse=0.
5. Assert reset low mid-run in O2 between clock edges → outputs go to reset values before the next clk edge; after release, w=1 leads to O1.
6. With RUN_LENGTH_FSM_DETCNT_EN defined and RUN_LEN=2: 300 alternating pairs (0,0,1,1,…) → det_cnt saturates at 255; clr returns it to 0.
